round_robin_arbiter: RTL and testbench



---
 rtl/round_robin_arbiter_pkg.sv | 24 ++
 rtl/round_robin_arbiter_fixed_priority_grant.sv | 14 +
 rtl/round_robin_arbiter.sv | 162 ++++++++++++++++
 tb/tb_round_robin_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/round_robin_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter:
// the FSM state encoding and a constant clog2 helper
// used to size counters at elaboration.
package round_robin_arbiter_pkg;

  // IDLE: no owner. BUSY: exactly one grant bit is set.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/round_robin_arbiter_fixed_priority_grant.sv
// Combinational fixed-priority grant stage: the lowest set
// request bit wins and is returned as a one-hot vector.
// An all-zero request gives an all-zero grant.
module round_robin_arbiter_fixed_priority_grant #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_req,
  output logic [WIDTH-1:0] o_grant
);

  // Two's-complement trick: req & -req isolates the lowest set bit.
  assign o_grant = i_req & (~i_req + WIDTH'(1));

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with a registered one-hot grant.
//
// Optional build macro: ROUND_ROBIN_TIMEOUT_EN
//   defined   - the owner is forcibly released after MAX_HOLD busy
//               cycles without a release, and o_timeout pulses once.
//   undefined - no hold counter; o_timeout is tied low and an owner
//               may keep the grant indefinitely.
//
// Handshake: the arbiter leaves IDLE as soon as any request is seen and
// registers a one-hot grant at that edge. The owner keeps the grant while
// its request stays high and until it pulses i_release (or drops its
// request). The grant then drops for one dead cycle before the next owner
// is chosen. Requests are only examined in IDLE.
//
// Priority: after an owner releases, only requesters with a strictly
// higher index are eligible through the masked path; if none of them
// request, the unmasked path picks the lowest requester (wrap-around).
module round_robin_arbiter #(
  parameter int WIDTH    = 8,
  parameter int ID_W     = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_request,
  input  logic             i_release,
  output logic [WIDTH-1:0] o_grant,
  output logic             o_grant_valid,
  output logic [ID_W-1:0]  o_grant_id,
  output logic             o_timeout,
  output logic             o_state
);

  import round_robin_arbiter_pkg::*;

  state_t           r_state;
  logic [WIDTH-1:0] r_grant;
  logic             r_grant_valid;
  logic [WIDTH-1:0] r_mask;

  logic [WIDTH-1:0] w_masked_req;
  logic [WIDTH-1:0] w_grant_masked;
  logic [WIDTH-1:0] w_grant_unmasked;
  logic [WIDTH-1:0] w_winner;
  logic [WIDTH-1:0] w_next_mask;
  logic [ID_W-1:0]  w_grant_id;
  logic             w_owner_req;
  logic             w_release_norm;
  logic             w_force;
  logic             w_release_any;

  assign w_masked_req = i_request & r_mask;

  round_robin_arbiter_fixed_priority_grant #(
    .WIDTH (WIDTH)
  ) u_fpg_masked (
    .i_req   (w_masked_req),
    .o_grant (w_grant_masked)
  );

  round_robin_arbiter_fixed_priority_grant #(
    .WIDTH (WIDTH)
  ) u_fpg_unmasked (
    .i_req   (i_request),
    .o_grant (w_grant_unmasked)
  );

  // Masked path has priority; the unmasked path covers the wrap-around.
  assign w_winner = (|w_masked_req) ? w_grant_masked : w_grant_unmasked;

  // Bits strictly above the current owner; zero when the owner is the top bit.
  assign w_next_mask = ~((r_grant << 1) - WIDTH'(1));

  // Owner's request still asserted; dropping it is an implicit release.
  assign w_owner_req    = |(i_request & r_grant);
  assign w_release_norm = i_release | ~w_owner_req;
  assign w_release_any  = w_release_norm | w_force;

`ifdef ROUND_ROBIN_TIMEOUT_EN
  localparam int HOLD_W = clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_timeout;

  // The counter holds the number of busy cycles already completed, so the
  // MAX_HOLD-th busy cycle is the one that sees MAX_HOLD-1.
  assign w_force = (r_state == ST_BUSY) && (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // Hold counter and timeout pulse; a normal release suppresses the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_hold_cnt <= '0;
      end else if (!w_release_any) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end
      if (w_force && !w_release_norm) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_force   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Arbitration FSM: registers grant, valid flag, priority mask and state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_mask        <= '1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|i_request) begin
            r_state       <= ST_BUSY;
            r_grant       <= w_winner;
            r_grant_valid <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_release_any) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_mask        <= w_next_mask;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
          r_mask        <= '1;
        end
      endcase
    end
  end

  // Inline one-hot to binary encode of the registered grant; 0 when idle.
  always_comb begin
    w_grant_id = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_grant[i]) begin
        w_grant_id = w_grant_id | ID_W'(i);
      end
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = r_grant_valid;
  assign o_grant_id    = w_grant_id;
  assign o_state       = r_state;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter (WIDTH=4, MAX_HOLD=3). A pointer-based
// round-robin model tracks owner / last owner / busy cycles and is compared
// against the DUT every cycle; directed steps pin the model with literals.
module tb_round_robin_arbiter;

  localparam int WIDTH    = 4;
  localparam int ID_W     = 2;
  localparam int MAX_HOLD = 3;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] request = '0;
  logic             release_i = 1'b0;
  logic [WIDTH-1:0] grant;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_id;
  logic             timeout;
  logic             state;

  always #5 clk = ~clk;

  round_robin_arbiter #(
    .WIDTH    (WIDTH),
    .ID_W     (ID_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_request     (request),
    .i_release     (release_i),
    .o_grant       (grant),
    .o_grant_valid (grant_valid),
    .o_grant_id    (grant_id),
    .o_timeout     (timeout),
    .o_state       (state)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owner = -1;  // current owner index, -1 when idle
  int m_last  = -1;  // last released owner, -1 after reset
  int m_busy  = 0;   // busy cycles completed by current owner
  bit m_to    = 1'b0;

  // Search upward from the slot after the last owner, wrapping around.
  function automatic int pick(input logic [WIDTH-1:0] req, input int last);
    for (int k = 1; k <= WIDTH; k++) begin
      int idx;
      idx = (last + k) % WIDTH;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    bit rel;
    bit forced;
    if (rst) begin
      m_owner = -1;
      m_last  = -1;
      m_busy  = 0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        if (request != '0) begin
          m_owner = pick(request, m_last);
          m_busy  = 0;
        end
      end else begin
        rel    = release_i || !request[m_owner];
        forced = 1'b0;
`ifdef ROUND_ROBIN_TIMEOUT_EN
        m_busy++;
        forced = (m_busy >= MAX_HOLD);
`endif
        if (rel || forced) begin
          m_to    = forced && !rel;
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(posedge clk) begin
    logic [WIDTH-1:0] exp_g;
    #1;
    if (cmp_en) begin
      exp_g = (m_owner < 0) ? '0 : WIDTH'(1 << m_owner);
      chk("model_grant", 32'(grant), 32'(exp_g));
      chk("model_valid", 32'(grant_valid), 32'(m_owner >= 0));
      chk("model_id", 32'(grant_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
      chk("model_timeout", 32'(timeout), 32'(m_to));
      chk("model_state", 32'(state), 32'(m_owner >= 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_grant(input string name, input logic [WIDTH-1:0] g, input int id);
    chk({name, "_grant"}, 32'(grant), 32'(g));
    chk({name, "_valid"}, 32'(grant_valid), 32'(g != '0));
    chk({name, "_id"}, 32'(grant_id), 32'(id));
  endtask

  // Release pulse: grant must drop at the edge that samples it.
  task automatic pulse_release(input string name);
    release_i = 1'b1;
    step();
    release_i = 1'b0;
    expect_grant({name, "_dead"}, 4'b0000, 0);
  endtask

  initial begin
    cmp_en = 1'b1;
    rst = 1'b1;
    step();
    step();
    expect_grant("reset", 4'b0000, 0);
    chk("reset_timeout", 32'(timeout), 32'd0);

    // Full rotation with all four requesting.
    rst = 1'b0;
    request = 4'b1111;
    step();
    expect_grant("rot0", 4'b0001, 0);
    pulse_release("rot1");
    step();
    expect_grant("rot1", 4'b0010, 1);
    pulse_release("rot2");
    step();
    expect_grant("rot2", 4'b0100, 2);
    pulse_release("rot3");
    step();
    expect_grant("rot3", 4'b1000, 3);
    pulse_release("wrap");
    step();
    expect_grant("wrap", 4'b0001, 0);

    // Owner 0 releases while still requesting: bit 2 wins.
    request = 4'b0101;
    pulse_release("rereq");
    step();
    expect_grant("rereq", 4'b0100, 2);

    // Owner 2 drops its request: implicit release, then wrap to bit 1.
    request = 4'b0010;
    step();
    expect_grant("implicit_dead", 4'b0000, 0);
    step();
    expect_grant("implicit_wrap", 4'b0010, 1);

    // Reset while busy with owner 2.
    request = 4'b0100;
    pulse_release("pre_rst");
    step();
    expect_grant("pre_rst", 4'b0100, 2);
    rst = 1'b1;
    step();
    expect_grant("mid_rst", 4'b0000, 0);
    rst = 1'b0;
    request = 4'b1010;
    step();
    expect_grant("post_rst", 4'b0010, 1);

    // Release while idle is ignored.
    request = 4'b0000;
    step();
    expect_grant("idle_drop", 4'b0000, 0);
    release_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_grant("idle_rel", 4'b0000, 0);
      chk("idle_rel_state", 32'(state), 32'd0);
    end
    release_i = 1'b0;

    // Hold without release.
    request = 4'b0010;
    step();
    expect_grant("hold_start", 4'b0010, 1);
    request = 4'b0110;
`ifdef ROUND_ROBIN_TIMEOUT_EN
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      step();
      expect_grant("hold", 4'b0010, 1);
      chk("hold_timeout", 32'(timeout), 32'd0);
    end
    step();
    expect_grant("timeout_drop", 4'b0000, 0);
    chk("timeout_pulse", 32'(timeout), 32'd1);
    step();
    expect_grant("after_timeout", 4'b0100, 2);
    chk("timeout_clear", 32'(timeout), 32'd0);
`else
    for (int i = 0; i < 55; i++) begin
      step();
      expect_grant("hold", 4'b0010, 1);
      chk("hold_timeout", 32'(timeout), 32'd0);
    end
`endif

    // Randomized phase; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 2) == 0) request = WIDTH'($urandom_range(0, 15));
      end
      release_i = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    release_i = 1'b0;
    step();
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
